lc_readout_arbiter: RTL and testbench
=====================================

LC_READOUT_ARBITER -- requirements
Module: lc_readout_arbiter

Interface
REQ-001 SHALL have parameter N_CHANNELS, default 24: number of local-coincidence channels (2..32).
REQ-002 SHALL have parameter CHAN_W, default 5: width of channel index, at least clog2(N_CHANNELS).
REQ-003 SHALL have port clk, input, 1: single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port enable, input, 1: arbiter enable.
REQ-006 SHALL have port local_coinc, input, N_CHANNELS: per-channel local-coincidence flags.
REQ-007 SHALL have port holdoff_len, input, 16: post-readout deadtime, in clocks.
REQ-008 SHALL have port rd_req_valid, output, 1: readout request to the shared digitizer path.
REQ-009 SHALL have port rd_req_chan, output, CHAN_W: channel being requested.
REQ-010 SHALL have port rd_req_ready, input, 1: readout path accepts the request.
REQ-011 SHALL have port rd_done, input, 1: single-cycle pulse when the readout completes.
REQ-012 SHALL have port pending, output, N_CHANNELS: per-channel pending flags.
REQ-013 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-014 SHALL have port dropped_cnt, output, 16: count of dropped events, saturating.
REQ-015 SHALL have port timeout, output, 1: single-cycle pulse on readout timeout.

Function
REQ-016 SHALL detect rising edges of local_coinc using a registered previous value.
REQ-017 SHALL set pending[i] on a rising edge of channel i when enable=1.
REQ-018 SHALL count a drop instead of setting pending when the channel is already pending, or is the in-flight channel (REQ or WAIT_DONE); dropped_cnt saturates at 0xFFFF.
REQ-019 SHALL count one drop per offending channel when several channels hit this condition in the same cycle; the increment is the popcount of those channels.
REQ-020 SHALL, when enable=0, ignore edges, clear all pending flags and complete any in-flight transaction normally.
REQ-021 SHALL implement the FSM states IDLE, REQ, WAIT_DONE, HOLDOFF.
REQ-022 SHALL, in IDLE with any pending bit set, register a round-robin pick into rd_req_chan and go to REQ; the search starts at last_grant+1 modulo N_CHANNELS.
REQ-023 SHALL hold rd_req_valid=1 only in REQ, with rd_req_chan stable until rd_req_valid and rd_req_ready are both high in the same cycle.
REQ-024 SHALL, on that handshake, clear the granted pending bit, update last_grant and go to WAIT_DONE.
REQ-025 SHALL keep pending set when the granted channel's edge arrives in the same cycle as its handshake; the new event wins.
REQ-026 SHALL go from WAIT_DONE to HOLDOFF on rd_done; rd_done in any other state is ignored.
REQ-027 SHALL load holdoff_len on HOLDOFF entry and count down to IDLE; holdoff_len=0 skips from WAIT_DONE directly to IDLE.
REQ-028 SHALL give a latency of 2 clocks from the sampled local_coinc rise to rd_req_valid when idle and not in holdoff.
REQ-029 SHALL NOT drop an event when a pending channel is raised while the FSM is busy; it waits for the next arbitration.

Reset
REQ-030 SHALL, on rst, asynchronously force: state=IDLE, pending=0, previous local_coinc=0, rd_req_valid=0, rd_req_chan=0, last_grant=N_CHANNELS-1, dropped_cnt=0, busy=0, timeout=0, holdoff and timeout counters=0.
REQ-031 SHALL, on rst mid-transaction, abandon the request immediately; no rd_done is awaited after release.

Configuration
REQ-032 SHALL, with LC_ARB_TIMEOUT_EN defined, count WAIT_DONE cycles against the constant LC_ARB_TIMEOUT_CYCLES (65535).
REQ-033 SHALL, on reaching that count, pulse timeout for one cycle and go to HOLDOFF as if rd_done had arrived.
REQ-034 SHALL, without LC_ARB_TIMEOUT_EN, tie timeout to 0, omit the counter, and wait indefinitely in WAIT_DONE.

Structure
REQ-035 SHALL place the state encoding typedef, LC_ARB_TIMEOUT_CYCLES and the default CHAN_W in package lc_arb_pkg.
REQ-036 SHALL implement the round-robin pick as a combinational sub-module, rr_picker: request vector plus last_grant in, index plus found out.

Verification
REQ-037 SHALL cover single event: holdoff_len=4, ready tied 1, local_coinc[3] rises -> rd_req_valid 2 clocks later with chan=3; pending[3] clears; after rd_done, busy falls 5 clocks later.
REQ-038 SHALL cover fairness: channels 2, 7 and 20 rise together, last_grant=7 -> grants in order 20, 2, 7.
REQ-039 SHALL cover drops: channel 5 pending, then channel 5 rises twice more before its grant -> dropped_cnt=2; then force dropped_cnt to 0xFFFF plus one more drop -> stays 0xFFFF.
REQ-040 SHALL cover backpressure: rd_req_ready held 0 for 10 cycles -> valid stays 1 and chan is unchanged; grant happens on the cycle ready=1.
REQ-041 SHALL cover timeout: with LC_ARB_TIMEOUT_EN, no rd_done -> timeout pulse at cycle 65535 of WAIT_DONE, then HOLDOFF; without the macro, FSM remains in WAIT_DONE.
REQ-042 SHALL cover reset in WAIT_DONE: assert rst -> all outputs reset at once; a fresh event after release is served normally.

Source files
------------

// File: rtl/lc_arb_pkg.sv
// Shared definitions for the local-coincidence readout arbiter.
//   lc_arb_state_e        : arbiter FSM states
//   LC_ARB_TIMEOUT_CYCLES : WAIT_DONE cycle limit (used only with LC_ARB_TIMEOUT_EN)
//   LC_ARB_CHAN_W         : default channel-index width
package lc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DONE,
    HOLDOFF
  } lc_arb_state_e;

  localparam int unsigned LC_ARB_TIMEOUT_CYCLES = 65535;
  localparam int unsigned LC_ARB_CHAN_W         = 5;

endpackage

// File: rtl/lc_readout_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per channel
//   last_grant : most recently granted channel; search starts at last_grant+1
//   idx        : selected channel (0 when nothing requested)
//   found      : high when any request bit is set
module rr_picker
  import lc_arb_pkg::*;
#(
  parameter int unsigned N_CHANNELS = 24,
  parameter int unsigned CHAN_W     = LC_ARB_CHAN_W
) (
  input  logic [N_CHANNELS-1:0] req,
  input  logic [CHAN_W-1:0]     last_grant,
  output logic [CHAN_W-1:0]     idx,
  output logic                  found
);

  logic [31:0] best;
  logic [31:0] off;

  // Each requester's distance from last_grant+1 (mod N); the nearest wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    best  = N_CHANNELS;
    off   = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      off = (i + N_CHANNELS - 1 - 32'(last_grant)) % N_CHANNELS;
      if (req[i] && (off < best)) begin
        best  = off;
        idx   = CHAN_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lc_readout_arbiter.sv
// Local-coincidence readout arbiter: turns per-channel rising edges into
// pending flags and serves them one at a time, round-robin, over a shared
// request/ready readout path, followed by a programmable deadtime.
//   clk, rst (async, active-high), enable
//   local_coinc   : per-channel coincidence flags (edge-detected)
//   holdoff_len   : deadtime after each readout, in clocks (0 = none)
//   rd_req_valid/rd_req_chan/rd_req_ready : readout request handshake
//   rd_done       : readout complete pulse
//   pending       : per-channel pending flags
//   busy          : FSM not idle
//   dropped_cnt   : saturating count of events lost to an already-pending channel
//   timeout       : WAIT_DONE timeout pulse
// Optional: define LC_ARB_TIMEOUT_EN to abandon a readout after
// LC_ARB_TIMEOUT_CYCLES cycles in WAIT_DONE; otherwise timeout is 0.
module lc_readout_arbiter
  import lc_arb_pkg::*;
#(
  parameter int unsigned N_CHANNELS = 24,
  parameter int unsigned CHAN_W     = LC_ARB_CHAN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [N_CHANNELS-1:0] local_coinc,
  input  logic [15:0]           holdoff_len,
  output logic                  rd_req_valid,
  output logic [CHAN_W-1:0]     rd_req_chan,
  input  logic                  rd_req_ready,
  input  logic                  rd_done,
  output logic [N_CHANNELS-1:0] pending,
  output logic                  busy,
  output logic [15:0]           dropped_cnt,
  output logic                  timeout
);

  lc_arb_state_e         state_q, state_d;
  logic [N_CHANNELS-1:0] lc_prev;
  logic [N_CHANNELS-1:0] rise, grant_oh, inflight, clear_oh, conflict, pending_d;
  logic [CHAN_W-1:0]     last_grant, last_d, chan_d, pick_idx;
  logic                  pick_found, hs, to_fire;
  logic [15:0]           hold_cnt, hold_d, drop_inc, dropped_d;
  logic [16:0]           drop_sum;

  rr_picker #(
    .N_CHANNELS(N_CHANNELS),
    .CHAN_W    (CHAN_W)
  ) u_pick (
    .req       (pending),
    .last_grant(last_grant),
    .idx       (pick_idx),
    .found     (pick_found)
  );

  // Pending/drop bookkeeping. An edge on the granted channel in its handshake
  // cycle is a fresh event: the clear is overridden and no drop is counted.
  always_comb begin
    rise     = local_coinc & ~lc_prev;
    hs       = (state_q == REQ) && rd_req_ready;
    grant_oh = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      grant_oh[i] = (32'(rd_req_chan) == i);
    end
    inflight  = ((state_q == REQ) || (state_q == WAIT_DONE)) ? grant_oh : '0;
    clear_oh  = hs ? grant_oh : '0;
    conflict  = enable ? (rise & (pending | inflight) & ~clear_oh) : '0;
    pending_d = enable ? ((pending & ~clear_oh) | (rise & ~conflict)) : '0;
    drop_inc  = '0;
    for (int unsigned i = 0; i < N_CHANNELS; i++) begin
      drop_inc = drop_inc + 16'(conflict[i]);
    end
    drop_sum  = {1'b0, dropped_cnt} + {1'b0, drop_inc};
    dropped_d = drop_sum[16] ? '1 : drop_sum[15:0];
  end

`ifdef LC_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt <= '0;
    else     to_cnt <= (state_q == WAIT_DONE) ? to_cnt + 16'd1 : '0;
  end

  assign to_fire = (state_q == WAIT_DONE) && (to_cnt == 16'(LC_ARB_TIMEOUT_CYCLES - 1));
`else
  assign to_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    chan_d  = rd_req_chan;
    last_d  = last_grant;
    hold_d  = hold_cnt;
    case (state_q)
      IDLE: begin
        if (enable && pick_found) begin
          chan_d  = pick_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        if (rd_req_ready) begin
          last_d  = rd_req_chan;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (rd_done || to_fire) begin
          if (holdoff_len == 16'd0) begin
            state_d = IDLE;
          end else begin
            hold_d  = holdoff_len;
            state_d = HOLDOFF;
          end
        end
      end
      HOLDOFF: begin
        hold_d = hold_cnt - 16'd1;
        if (hold_cnt <= 16'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lc_prev     <= '0;
      pending     <= '0;
      rd_req_chan <= '0;
      last_grant  <= CHAN_W'(N_CHANNELS - 1);
      dropped_cnt <= '0;
      hold_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      lc_prev     <= local_coinc;
      pending     <= pending_d;
      rd_req_chan <= chan_d;
      last_grant  <= last_d;
      dropped_cnt <= dropped_d;
      hold_cnt    <= hold_d;
    end
  end

  assign rd_req_valid = (state_q == REQ);
  assign busy         = (state_q != IDLE);
  assign timeout      = to_fire;

endmodule

// File: tb/tb_lc_readout_arbiter.sv
module tb_lc_readout_arbiter;

  localparam int N  = 24;
  localparam int CW = 5;
  localparam int PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2, PH_HOLD = 3;
`ifdef LC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int LONG_WAIT = 65545;
`else
  localparam bit TO_EN = 1'b0;
  localparam int LONG_WAIT = 300;
`endif

  logic          clk = 1'b0;
  logic          rst, enable, rd_req_ready, rd_done;
  logic [N-1:0]  local_coinc;
  logic [15:0]   holdoff_len;
  logic          rd_req_valid, busy, timeout;
  logic [CW-1:0] rd_req_chan;
  logic [N-1:0]  pending;
  logic [15:0]   dropped_cnt;

  always #5 clk = ~clk;

  lc_readout_arbiter #(.N_CHANNELS(N), .CHAN_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .local_coinc(local_coinc),
    .holdoff_len(holdoff_len), .rd_req_valid(rd_req_valid), .rd_req_chan(rd_req_chan),
    .rd_req_ready(rd_req_ready), .rd_done(rd_done), .pending(pending), .busy(busy),
    .dropped_cnt(dropped_cnt), .timeout(timeout)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [N-1:0] m_prev, m_pend;
  int m_phase, m_chan, m_last, m_hold, m_wcyc, m_drops;
  int exp_q[$];
  bit mon_on = 1'b0;

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] p, int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (p[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_phase = PH_IDLE; m_chan = 0; m_last = N - 1;
    m_hold = 0; m_wcyc = 0; m_drops = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [N-1:0] nxt;
    int  drops_now;
    bit  hs;
    hs  = (m_phase == PH_REQ) && rd_req_ready;
    nxt = m_pend;
    if (hs) nxt[m_chan] = 1'b0;
    drops_now = 0;
    if (enable) begin
      for (int i = 0; i < N; i++) begin
        if (local_coinc[i] && !m_prev[i]) begin
          if (hs && i == m_chan) nxt[i] = 1'b1;
          else if (m_pend[i] || ((m_phase == PH_REQ || m_phase == PH_WAIT) && i == m_chan)) drops_now++;
          else nxt[i] = 1'b1;
        end
      end
    end else begin
      nxt = '0;
    end
    m_drops = (m_drops + drops_now > 65535) ? 65535 : m_drops + drops_now;
    m_prev  = local_coinc;
    case (m_phase)
      PH_IDLE: if (enable && m_pend != '0) begin
        m_chan  = rr_pick(m_pend, m_last);
        m_phase = PH_REQ;
        exp_q.push_back(m_chan);
      end
      PH_REQ: if (rd_req_ready) begin
        m_last = m_chan; m_phase = PH_WAIT; m_wcyc = 0;
      end
      PH_WAIT: begin
        m_wcyc++;
        if (rd_done || (TO_EN && m_wcyc == 65535)) begin
          if (holdoff_len == 16'd0) m_phase = PH_IDLE;
          else begin m_phase = PH_HOLD; m_hold = holdoff_len; end
        end
      end
      default: begin
        m_hold--;
        if (m_hold == 0) m_phase = PH_IDLE;
      end
    endcase
    m_pend = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic run(int n, int done_pct);
    for (int i = 0; i < n; i++) begin
      rd_done = ($urandom_range(0, 99) < done_pct);
      tick();
    end
    rd_done = 1'b0;
  endtask

  // Monitor: compares DUT outputs with the model each cycle and pops the
  // expected grant on every handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        check("rd_req_valid", rd_req_valid, m_phase == PH_REQ);
        check("busy", busy, m_phase != PH_IDLE);
        check("pending", pending, m_pend);
        check("dropped_cnt", dropped_cnt, m_drops);
        check("timeout", timeout, TO_EN && m_phase == PH_WAIT && m_wcyc == 65534);
        if (m_phase == PH_REQ) check("rd_req_chan", rd_req_chan, m_chan);
        if (rd_req_valid && rd_req_ready && !rst) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL grant: got handshake on chan %0d expected none", rd_req_chan);
          end else begin
            check("grant_chan", rd_req_chan, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; local_coinc = '0; holdoff_len = 16'd4;
    rd_req_ready = 1'b0; rd_done = 1'b0;
    model_reset();
    mon_on = 1'b1;
    repeat (3) tick();
    rst = 1'b0; enable = 1'b1;
    tick();

    // Single event, holdoff 4, ready tied high.
    rd_req_ready = 1'b1; local_coinc[3] = 1'b1; run(3, 0);
    local_coinc[3] = 1'b0; run(2, 0);
    rd_done = 1'b1; tick(); rd_done = 1'b0;
    run(8, 0);

    // Fairness: make channel 7 the last grant, then raise 2, 7, 20 together.
    holdoff_len = 16'd2;
    local_coinc[7] = 1'b1; run(4, 0); local_coinc = '0;
    rd_done = 1'b1; tick(); rd_done = 1'b0; run(4, 0);
    local_coinc[2] = 1'b1; local_coinc[7] = 1'b1; local_coinc[20] = 1'b1; tick();
    local_coinc = '0; run(40, 20);

    // Drops on an in-flight channel, a busy-time event that must wait,
    // then 10 cycles of backpressure.
    rd_req_ready = 1'b0; local_coinc[5] = 1'b1; run(3, 0);
    local_coinc[5] = 1'b0; tick(); local_coinc[5] = 1'b1; tick();
    local_coinc[5] = 1'b0; tick(); local_coinc[5] = 1'b1; tick();
    local_coinc[6] = 1'b1; tick();
    run(10, 0);
    rd_req_ready = 1'b1; run(30, 25);
    local_coinc = '0; run(10, 25);

    // Saturate the drop counter with every channel held pending.
    rd_req_ready = 1'b0;
    for (int i = 0; i < 5600; i++) begin
      local_coinc = (i % 2 == 0) ? '1 : '0;
      tick();
    end
    local_coinc = '0; tick(); local_coinc[0] = 1'b1; tick();
    local_coinc = '0; rd_req_ready = 1'b1; run(400, 30);

    // Reset while in WAIT_DONE, then a fresh event.
    holdoff_len = 16'd3; local_coinc[9] = 1'b1; run(4, 0);
    rst = 1'b1; model_reset(); local_coinc = '0; tick(); tick();
    rst = 1'b0; tick();
    local_coinc[11] = 1'b1; run(3, 0); local_coinc = '0; run(20, 30);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) local_coinc[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 30) == 0) local_coinc ^= N'($urandom);
      enable       = ($urandom_range(0, 19) != 0);
      rd_req_ready = 1'($urandom_range(0, 1));
      rd_done      = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 49) == 0) holdoff_len = 16'($urandom_range(0, 3));
      tick();
    end

    // Long WAIT_DONE with no rd_done.
    enable = 1'b1; local_coinc = '0; rd_req_ready = 1'b1; holdoff_len = 16'd1;
    run(150, 50);
    local_coinc[1] = 1'b1; run(4, 0); local_coinc = '0;
    run(LONG_WAIT, 0);
    rd_done = 1'b1; tick(); rd_done = 1'b0;

    // Drain.
    run(200, 30);
    check("grants_outstanding", exp_q.size(), 0);
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
